// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit: 8-state FSM plus combinational
// control decode of the registered state and the current opcode.
//
// Ports:
//   CLK, Reset (async, active-low)     clock and reset
//   opcode[5:0], zero                  instruction opcode, ALU zero flag
//   state[2:0]                         current FSM state
//   PCWre, IRWre, InsMemRW             PC / IR / instruction memory control
//   RegWre, RegDst[1:0], WrRegDSrc     register-file write control
//   ALUSrcA, ALUSrcB, ALUOp[2:0]       ALU operand / operation select
//   ExtSel                             immediate extension select
//   mRD, mWR, DBDataSrc                data memory / data bus control
//   PCSrc[1:0]                         next-PC select
//
// Build option: define CU_HALT_EN to make opcode 111111 a sticky halt
// (PC frozen, FSM idles IF/ID until Reset). Without it, 111111 is a NOP.

module control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_L   = 3'b100,
        S_EXE_B  = 3'b101,
        S_EXE_A  = 3'b110,
        S_WB_A   = 3'b111
    } state_t;

    state_t state_q, state_d;

    logic op_add, op_sub, op_addiu, op_and, op_andi, op_ori, op_slt;
    logic op_sw, op_lw, op_beq, op_bne, op_j, op_jr, op_jal;
    logic op_halt, op_rtype, op_imm, op_alu, op_jump, op_nop;
    logic halted;

    assign op_add   = (opcode == 6'b000000);
    assign op_sub   = (opcode == 6'b000001);
    assign op_addiu = (opcode == 6'b000010);
    assign op_and   = (opcode == 6'b010000);
    assign op_andi  = (opcode == 6'b010001);
    assign op_ori   = (opcode == 6'b010010);
    assign op_slt   = (opcode == 6'b100110);
    assign op_sw    = (opcode == 6'b110000);
    assign op_lw    = (opcode == 6'b110001);
    assign op_beq   = (opcode == 6'b110100);
    assign op_bne   = (opcode == 6'b110101);
    assign op_j     = (opcode == 6'b111000);
    assign op_jr    = (opcode == 6'b111001);
    assign op_jal   = (opcode == 6'b111010);

    assign op_rtype = op_add | op_sub | op_and | op_slt;
    assign op_imm   = op_addiu | op_andi | op_ori;
    assign op_alu   = op_rtype | op_imm;
    assign op_jump  = op_j | op_jr | op_jal;

`ifdef CU_HALT_EN
    logic halted_q, halted_d;

    assign op_halt = (opcode == 6'b111111);

    // Sticky until Reset: once a halt is decoded the core only idles.
    always_comb begin
        halted_d = halted_q;
        if (state_q == S_ID && op_halt) halted_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halted = halted_q;
`else
    assign op_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // Anything not decoded above (including 111111 when halt is not
    // built in) retires as a NOP that just advances the PC.
    assign op_nop = ~(op_alu | op_sw | op_lw | op_beq | op_bne |
                      op_jump | op_halt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                if (halted || op_jump || op_halt || op_nop)
                    state_d = S_IF;
                else if (op_beq || op_bne)
                    state_d = S_EXE_B;
                else if (op_lw || op_sw)
                    state_d = S_EXE_LS;
                else
                    state_d = S_EXE_A;
            end
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = op_lw ? S_WB_L : S_IF;
            S_WB_L:   state_d = S_IF;
            S_EXE_B:  state_d = S_IF;
            S_EXE_A:  state_d = S_WB_A;
            S_WB_A:   state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    logic in_if, in_id, in_exe, in_mem, in_wbl, in_wba, in_exb;
    logic id_live, br_taken;

    assign in_if   = (state_q == S_IF);
    assign in_id   = (state_q == S_ID);
    assign in_mem  = (state_q == S_MEM);
    assign in_wbl  = (state_q == S_WB_L);
    assign in_wba  = (state_q == S_WB_A);
    assign in_exb  = (state_q == S_EXE_B);
    assign in_exe  = (state_q == S_EXE_A) || in_wba ||
                     (state_q == S_EXE_LS) || in_exb;
    assign id_live = in_id && !halted;
    assign br_taken = (op_beq && zero) || (op_bne && !zero);

    always_comb begin
        IRWre     = in_if;
        InsMemRW  = in_if;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 3'b000;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;

        if (!halted) begin
            PCWre = (id_live && (op_jump || op_nop)) || in_exb ||
                    (in_mem && op_sw) || in_wbl || in_wba;
        end

        if (id_live && (op_j || op_jal)) PCSrc = 2'b11;
        else if (id_live && op_jr)       PCSrc = 2'b10;
        else if (in_exb && br_taken)     PCSrc = 2'b01;

        // jal links PC+4 into $31 during ID; RegDst/WrRegDSrc stay 0.
        RegWre    = in_wba || in_wbl || (id_live && op_jal);
        WrRegDSrc = in_wba || in_wbl;
        if (in_wba && op_rtype)                   RegDst = 2'b10;
        else if ((in_wba && op_imm) || in_wbl)    RegDst = 2'b01;

        if (in_exe) begin
            ALUSrcB = op_imm || op_lw || op_sw;
            ExtSel  = op_addiu || op_lw || op_sw || op_beq || op_bne;
            unique case (1'b1)
                op_sub, op_beq, op_bne: ALUOp = 3'b001;
                op_slt:                 ALUOp = 3'b010;
                op_and, op_andi:        ALUOp = 3'b100;
                op_ori:                 ALUOp = 3'b101;
                default:                ALUOp = 3'b000;
            endcase
        end

        mRD       = in_mem && op_lw;
        mWR       = in_mem && op_sw;
        DBDataSrc = (in_mem || in_wbl) && op_lw;
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected per-cycle control
// vectors are queued per scenario and compared as the FSM steps.

module tb_control_unit;

    logic       CLK, Reset, zero;
    logic [5:0] opcode;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwre, irwre, insmemrw, regwre;
        logic [1:0] regdst;
        logic       wrregdsrc, alusrca, alusrcb;
        logic [2:0] aluop;
        logic       extsel, mrd, mwr, dbdatasrc;
        logic [1:0] pcsrc;
    } out_t;

    out_t obs, e;
    out_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc;

    control_unit dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .state(state), .PCWre(PCWre), .IRWre(IRWre),
        .InsMemRW(InsMemRW), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .PCSrc(PCSrc)
    );

    assign obs = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst,
                  WrRegDSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, mRD,
                  mWR, DBDataSrc, PCSrc};

    always #5 CLK = ~CLK;

    function automatic out_t st(input logic [2:0] s);
        out_t o;
        o = '0;
        o.st = s;
        if (s == 3'b000) begin
            o.irwre = 1'b1;
            o.insmemrw = 1'b1;
        end
        return o;
    endfunction

    task automatic test_reset;
        out_t x;
        #1;
        exp_q.push_back(st(3'd0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_init got=%h exp=%h", obs, e);
        end
        opcode = 6'b111000;
        @(negedge CLK);
        Reset = 1'b1;
        exp_q.push_back(st(3'd0));
        x = st(3'd1); x.pcwre = 1; x.pcsrc = 2'b11;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_j cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
    endtask

    task automatic test_alu(input logic [5:0] op, input logic [2:0] aop,
                            input logic imm, input logic [1:0] dst);
        out_t x;
        opcode = op;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        x = st(3'd6); x.aluop = aop; x.alusrcb = imm;
        x.extsel = (op == 6'b000010);
        exp_q.push_back(x);
        x.st = 3'd7; x.pcwre = 1; x.regwre = 1; x.regdst = dst;
        x.wrregdsrc = 1;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL alu_%b cyc%0d got=%h exp=%h", op, cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
    endtask

    task automatic test_lw;
        out_t x;
        opcode = 6'b110001;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        x = st(3'd2); x.alusrcb = 1; x.extsel = 1;
        exp_q.push_back(x);
        x = st(3'd3); x.mrd = 1; x.dbdatasrc = 1;
        exp_q.push_back(x);
        x = st(3'd4); x.regwre = 1; x.regdst = 2'b01; x.wrregdsrc = 1;
        x.dbdatasrc = 1; x.pcwre = 1;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL lw cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
    endtask

    task automatic test_jump(input logic [5:0] op, input logic rw,
                             input logic [1:0] src);
        out_t x;
        opcode = op;
        exp_q.push_back(st(3'd0));
        x = st(3'd1); x.pcwre = 1; x.pcsrc = src; x.regwre = rw;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL jump_%b cyc%0d got=%h exp=%h", op, cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z,
                               input logic taken);
        out_t x;
        opcode = op;
        zero = z;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        x = st(3'd5); x.pcwre = 1; x.extsel = 1; x.aluop = 3'b001;
        x.pcsrc = taken ? 2'b01 : 2'b00;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL br_%b_z%0d cyc%0d got=%h exp=%h",
                         op, z, cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
        zero = 1'b0;
    endtask

    task automatic test_reset_mid_sw;
        out_t x;
        opcode = 6'b110000;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        x = st(3'd2); x.alusrcb = 1; x.extsel = 1;
        exp_q.push_back(x);
        x = st(3'd3); x.mwr = 1; x.pcwre = 1;
        exp_q.push_back(x);
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL sw cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
        #1 Reset = 1'b0;
        #1;
        exp_q.push_back(st(3'd0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL sw_async_rst got=%h exp=%h", obs, e);
        end
        @(negedge CLK);
        Reset = 1'b1;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        x = st(3'd2); x.alusrcb = 1; x.extsel = 1;
        exp_q.push_back(x);
        x = st(3'd3); x.mwr = 1; x.pcwre = 1;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL sw_rerun cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
    endtask

    task automatic test_halt;
        out_t x;
        opcode = 6'b111111;
`ifdef CU_HALT_EN
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(st(3'd0));
            exp_q.push_back(st(3'd1));
        end
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL halt cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() == 4) opcode = 6'b111010;
            if (exp_q.size() > 0) @(negedge CLK);
        end
        Reset = 1'b0;
        opcode = 6'b000000;
        @(negedge CLK);
        Reset = 1'b1;
        exp_q.push_back(st(3'd0));
        exp_q.push_back(st(3'd1));
        exp_q.push_back(st(3'd6));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL halt_clear cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
`else
        exp_q.push_back(st(3'd0));
        x = st(3'd1); x.pcwre = 1;
        exp_q.push_back(x);
        exp_q.push_back(st(3'd0));
        cyc = 0;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL halt_nop cyc%0d got=%h exp=%h", cyc, obs, e);
            end
            cyc++;
            if (exp_q.size() > 0) @(negedge CLK);
        end
`endif
    endtask

    initial begin
        CLK = 1'b0;
        Reset = 1'b0;
        opcode = 6'b000000;
        zero = 1'b0;
        test_reset();
        test_alu(6'b000000, 3'b000, 1'b0, 2'b10);
        test_alu(6'b000001, 3'b001, 1'b0, 2'b10);
        test_alu(6'b010010, 3'b101, 1'b1, 2'b01);
        test_alu(6'b100110, 3'b010, 1'b0, 2'b10);
        test_alu(6'b000010, 3'b000, 1'b1, 2'b01);
        test_alu(6'b010001, 3'b100, 1'b1, 2'b01);
        test_lw();
        test_jump(6'b111010, 1'b1, 2'b11);
        test_jump(6'b111001, 1'b0, 2'b10);
        test_jump(6'b000011, 1'b0, 2'b00);
        test_branch(6'b110100, 1'b1, 1'b1);
        test_branch(6'b110100, 1'b0, 1'b0);
        test_branch(6'b110101, 1'b0, 1'b1);
        test_branch(6'b110101, 1'b1, 1'b0);
        test_reset_mid_sw();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
